// File: rtl/id_ex_stage_if.sv
// Bundle between the decode stage, the forwarding sources and the ID/EX
// pipeline register. Decode-side and forwarding signals run into the
// stage; EX-side operands and controls come out of it.
interface id_ex_stage_if #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5,
    parameter int CTRLW = 5
);
    logic             iValid;
    logic [RADDR-1:0] iRs1Addr;
    logic [RADDR-1:0] iRs2Addr;
    logic [RADDR-1:0] iRdAddr;
    logic [XLEN-1:0]  iRs1Data;
    logic [XLEN-1:0]  iRs2Data;
    logic [XLEN-1:0]  iImm;
    logic             iUseImm;
    logic [CTRLW-1:0] iAluCtrl;
    logic             iRegWrite;
    logic             iMemRead;
    logic             iMemWrite;
    logic             iFlush;
    logic [RADDR-1:0] iExMemRd;
    logic             iExMemRegWrite;
    logic [XLEN-1:0]  iExMemResult;
    logic [RADDR-1:0] iMemWbRd;
    logic             iMemWbRegWrite;
    logic [XLEN-1:0]  iMemWbResult;

    logic             oStall;
    logic             oValid;
    logic [CTRLW-1:0] oAluCtrl;
    logic [XLEN-1:0]  oA;
    logic [XLEN-1:0]  oB;
    logic [XLEN-1:0]  oStoreData;
    logic [RADDR-1:0] oRd;
    logic             oRegWrite;
    logic             oMemRead;
    logic             oMemWrite;

    modport master (
        output iValid, iRs1Addr, iRs2Addr, iRdAddr, iRs1Data, iRs2Data, iImm,
               iUseImm, iAluCtrl, iRegWrite, iMemRead, iMemWrite, iFlush,
               iExMemRd, iExMemRegWrite, iExMemResult,
               iMemWbRd, iMemWbRegWrite, iMemWbResult,
        input  oStall, oValid, oAluCtrl, oA, oB, oStoreData, oRd,
               oRegWrite, oMemRead, oMemWrite
    );

    modport slave (
        input  iValid, iRs1Addr, iRs2Addr, iRdAddr, iRs1Data, iRs2Data, iImm,
               iUseImm, iAluCtrl, iRegWrite, iMemRead, iMemWrite, iFlush,
               iExMemRd, iExMemRegWrite, iExMemResult,
               iMemWbRd, iMemWbRegWrite, iMemWbResult,
        output oStall, oValid, oAluCtrl, oA, oB, oStoreData, oRd,
               oRegWrite, oMemRead, oMemWrite
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU. Captures decoded fields, picks
// forwarded operands from EX/MEM or MEM/WB, stalls decode for one cycle on
// a load-use dependency (inserting a bubble) and drops the EX instruction
// on a branch flush.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5,
    parameter int CTRLW = 5
) (
    input logic           iClk,
    input logic           iRst_n,
    id_ex_stage_if.slave  bus
);

    logic             validQ;
    logic [RADDR-1:0] rs1Q;
    logic [RADDR-1:0] rs2Q;
    logic [RADDR-1:0] rdQ;
    logic [XLEN-1:0]  rs1DataQ;
    logic [XLEN-1:0]  rs2DataQ;
    logic [XLEN-1:0]  immQ;
    logic             useImmQ;
    logic [CTRLW-1:0] aluCtrlQ;
    logic             regWriteQ;
    logic             memReadQ;
    logic             memWriteQ;

    logic             stall;
    logic [XLEN-1:0]  fwdRs1;
    logic [XLEN-1:0]  fwdRs2;

    // Load-use detection: the load in EX targets a register the decode
    // instruction reads (rs2 only counts if it is really used); flush wins.
    always_comb begin
        stall = 1'b0;
        if (bus.iValid && validQ && memReadQ && (rdQ != '0) && !bus.iFlush) begin
            if ((bus.iRs1Addr == rdQ) ||
                ((bus.iRs2Addr == rdQ) && (!bus.iUseImm || bus.iMemWrite))) begin
                stall = 1'b1;
            end
        end
    end

    // Pipeline register: flush and hazard both leave a bubble, else capture.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            validQ    <= 1'b0;
            rs1Q      <= '0;
            rs2Q      <= '0;
            rdQ       <= '0;
            rs1DataQ  <= '0;
            rs2DataQ  <= '0;
            immQ      <= '0;
            useImmQ   <= 1'b0;
            aluCtrlQ  <= '0;
            regWriteQ <= 1'b0;
            memReadQ  <= 1'b0;
            memWriteQ <= 1'b0;
        end else if (bus.iFlush) begin
            validQ <= 1'b0;
        end else if (stall) begin
            validQ <= 1'b0;
        end else begin
            validQ    <= bus.iValid;
            rs1Q      <= bus.iRs1Addr;
            rs2Q      <= bus.iRs2Addr;
            rdQ       <= bus.iRdAddr;
            rs1DataQ  <= bus.iRs1Data;
            rs2DataQ  <= bus.iRs2Data;
            immQ      <= bus.iImm;
            useImmQ   <= bus.iUseImm;
            aluCtrlQ  <= bus.iAluCtrl;
            regWriteQ <= bus.iRegWrite;
            memReadQ  <= bus.iMemRead;
            memWriteQ <= bus.iMemWrite;
        end
    end

    // Operand forwarding: the younger EX/MEM result beats MEM/WB; x0 never forwards.
    always_comb begin
        fwdRs1 = rs1DataQ;
        fwdRs2 = rs2DataQ;
        if (bus.iExMemRegWrite && (bus.iExMemRd != '0) && (bus.iExMemRd == rs1Q)) begin
            fwdRs1 = bus.iExMemResult;
        end else if (bus.iMemWbRegWrite && (bus.iMemWbRd != '0) && (bus.iMemWbRd == rs1Q)) begin
            fwdRs1 = bus.iMemWbResult;
        end
        if (bus.iExMemRegWrite && (bus.iExMemRd != '0) && (bus.iExMemRd == rs2Q)) begin
            fwdRs2 = bus.iExMemResult;
        end else if (bus.iMemWbRegWrite && (bus.iMemWbRd != '0) && (bus.iMemWbRd == rs2Q)) begin
            fwdRs2 = bus.iMemWbResult;
        end
    end

    assign bus.oStall     = stall;
    assign bus.oValid     = validQ;
    assign bus.oAluCtrl   = aluCtrlQ;
    assign bus.oA         = fwdRs1;
    assign bus.oB         = useImmQ ? immQ : fwdRs2;
    assign bus.oStoreData = fwdRs2;
    assign bus.oRd        = rdQ;
    assign bus.oRegWrite  = regWriteQ & validQ;
    assign bus.oMemRead   = memReadQ & validQ;
    assign bus.oMemWrite  = memWriteQ & validQ;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for the ID/EX stage: directed scenarios followed by random traffic,
// all compared against an instruction-level model of what sits in EX.
module tb_id_ex_stage;

    logic clk;
    logic rstN;
    int   checks;
    int   errors;

    id_ex_stage_if #(.XLEN(32), .RADDR(5), .CTRLW(5)) bus ();

    id_ex_stage #(.XLEN(32), .RADDR(5), .CTRLW(5)) dut (
        .iClk   (clk),
        .iRst_n (rstN),
        .bus    (bus)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic        useImm;
        logic [4:0]  ctrl;
        logic        rw;
        logic        mr;
        logic        mw;
    } exInstT;

    exInstT ex;

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic void clearEx();
        ex = '{valid: 1'b0, rs1: '0, rs2: '0, rd: '0, d1: '0, d2: '0, imm: '0,
               useImm: 1'b0, ctrl: '0, rw: 1'b0, mr: 1'b0, mw: 1'b0};
    endfunction

    // Value a source register would actually hold when EX reads it.
    function automatic logic [31:0] sourceValue(input logic [4:0] addr, input logic [31:0] fileData);
        if (addr == 5'd0) return fileData;
        if (bus.iExMemRegWrite && bus.iExMemRd == addr) return bus.iExMemResult;
        if (bus.iMemWbRegWrite && bus.iMemWbRd == addr) return bus.iMemWbResult;
        return fileData;
    endfunction

    // Decode must wait if the EX load produces something it needs right now.
    function automatic logic needsStall();
        logic readsRs2;
        if (bus.iFlush || !bus.iValid || !ex.valid || !ex.mr || ex.rd == 5'd0) return 1'b0;
        readsRs2 = !bus.iUseImm || bus.iMemWrite;
        return (bus.iRs1Addr == ex.rd) || (readsRs2 && bus.iRs2Addr == ex.rd);
    endfunction

    task automatic compareModel();
        logic [31:0] a;
        logic [31:0] b2;
        checkOutput("stall", {31'd0, bus.oStall}, {31'd0, needsStall()});
        checkOutput("valid", {31'd0, bus.oValid}, {31'd0, ex.valid});
        checkOutput("regWrite", {31'd0, bus.oRegWrite}, {31'd0, ex.valid && ex.rw});
        checkOutput("memRead", {31'd0, bus.oMemRead}, {31'd0, ex.valid && ex.mr});
        checkOutput("memWrite", {31'd0, bus.oMemWrite}, {31'd0, ex.valid && ex.mw});
        if (ex.valid) begin
            a  = sourceValue(ex.rs1, ex.d1);
            b2 = sourceValue(ex.rs2, ex.d2);
            checkOutput("opA", bus.oA, a);
            checkOutput("opB", bus.oB, ex.useImm ? ex.imm : b2);
            checkOutput("storeData", bus.oStoreData, b2);
            checkOutput("aluCtrl", {27'd0, bus.oAluCtrl}, {27'd0, ex.ctrl});
            checkOutput("rd", {27'd0, bus.oRd}, {27'd0, ex.rd});
        end
    endtask

    function automatic void updateModel();
        if (!rstN) clearEx();
        else if (bus.iFlush || needsStall()) ex.valid = 1'b0;
        else ex = '{valid: bus.iValid, rs1: bus.iRs1Addr, rs2: bus.iRs2Addr, rd: bus.iRdAddr,
                    d1: bus.iRs1Data, d2: bus.iRs2Data, imm: bus.iImm, useImm: bus.iUseImm,
                    ctrl: bus.iAluCtrl, rw: bus.iRegWrite, mr: bus.iMemRead, mw: bus.iMemWrite};
    endfunction

    // Check the current cycle, clock it into the model, land on the next negedge.
    task automatic stepCycle();
        #1;
        compareModel();
        @(posedge clk);
        updateModel();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic randomize);
        if (!randomize) begin
            bus.iValid = 0; bus.iRs1Addr = 0; bus.iRs2Addr = 0; bus.iRdAddr = 0;
            bus.iRs1Data = 0; bus.iRs2Data = 0; bus.iImm = 0; bus.iUseImm = 0;
            bus.iAluCtrl = 0; bus.iRegWrite = 0; bus.iMemRead = 0; bus.iMemWrite = 0;
            bus.iFlush = 0; bus.iExMemRd = 0; bus.iExMemRegWrite = 0; bus.iExMemResult = 0;
            bus.iMemWbRd = 0; bus.iMemWbRegWrite = 0; bus.iMemWbResult = 0;
        end else begin
            bus.iValid         = ($urandom_range(0, 3) != 0);
            bus.iRs1Addr       = 5'($urandom_range(0, 7));
            bus.iRs2Addr       = 5'($urandom_range(0, 7));
            bus.iRdAddr        = 5'($urandom_range(0, 7));
            bus.iRs1Data       = $urandom;
            bus.iRs2Data       = $urandom;
            bus.iImm           = $urandom;
            bus.iUseImm        = 1'($urandom_range(0, 1));
            bus.iAluCtrl       = 5'($urandom);
            bus.iRegWrite      = 1'($urandom_range(0, 1));
            bus.iMemRead       = ($urandom_range(0, 2) == 0);
            bus.iMemWrite      = ($urandom_range(0, 3) == 0);
            bus.iFlush         = ($urandom_range(0, 7) == 0);
            bus.iExMemRd       = 5'($urandom_range(0, 7));
            bus.iExMemRegWrite = 1'($urandom_range(0, 1));
            bus.iExMemResult   = $urandom;
            bus.iMemWbRd       = 5'($urandom_range(0, 7));
            bus.iMemWbRegWrite = 1'($urandom_range(0, 1));
            bus.iMemWbResult   = $urandom;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Valid"}, {31'd0, bus.oValid}, 32'd0);
        checkOutput({tag, "Stall"}, {31'd0, bus.oStall}, 32'd0);
        checkOutput({tag, "AluCtrl"}, {27'd0, bus.oAluCtrl}, 32'd0);
        checkOutput({tag, "A"}, bus.oA, 32'd0);
        checkOutput({tag, "B"}, bus.oB, 32'd0);
        checkOutput({tag, "Store"}, bus.oStoreData, 32'd0);
        checkOutput({tag, "Rd"}, {27'd0, bus.oRd}, 32'd0);
        checkOutput({tag, "Flags"}, {29'd0, bus.oRegWrite, bus.oMemRead, bus.oMemWrite}, 32'd0);
    endtask

    // Directed scenarios, then random traffic, then the summary.
    initial begin
        checks = 0;
        errors = 0;
        clearEx();
        rstN = 1'b0;
        applyStimulus(1'b0);
        @(negedge clk);
        #1;
        checkAllZero("reset");
        stepCycle();
        rstN = 1'b1;

        // Pass-through with immediate operand
        bus.iValid = 1; bus.iRs1Addr = 3; bus.iRs1Data = 32'h10; bus.iRdAddr = 4;
        bus.iUseImm = 1; bus.iImm = 32'hFFFF_FFFC; bus.iAluCtrl = 5'd0; bus.iRegWrite = 1;
        stepCycle();
        #1;
        checkOutput("passA", bus.oA, 32'h10);
        checkOutput("passB", bus.oB, 32'hFFFF_FFFC);
        checkOutput("passValid", {31'd0, bus.oValid}, 32'd1);

        // Forwarding priority on rs1=5
        applyStimulus(1'b0);
        bus.iValid = 1; bus.iRs1Addr = 5; bus.iRs1Data = 32'h1234; bus.iRdAddr = 6;
        stepCycle();
        bus.iValid = 0;
        bus.iExMemRd = 5; bus.iExMemRegWrite = 1; bus.iExMemResult = 32'hAAAA;
        bus.iMemWbRd = 5; bus.iMemWbRegWrite = 1; bus.iMemWbResult = 32'hBBBB;
        #1;
        checkOutput("fwdExMem", bus.oA, 32'hAAAA);
        bus.iExMemRegWrite = 0;
        #1;
        checkOutput("fwdMemWb", bus.oA, 32'hBBBB);
        bus.iExMemRegWrite = 1; bus.iExMemRd = 0; bus.iMemWbRd = 0;
        #1;
        checkOutput("fwdRdZero", bus.oA, 32'h1234);
        bus.iValid = 1; bus.iRs1Addr = 0; bus.iRs1Data = 32'h5555;
        stepCycle();
        #1;
        checkOutput("fwdX0", bus.oA, 32'h5555);

        // Load-use on rs2, bubble, then MEM/WB forward
        applyStimulus(1'b0);
        bus.iValid = 1; bus.iMemRead = 1; bus.iRegWrite = 1; bus.iRdAddr = 7; bus.iUseImm = 1;
        stepCycle();
        applyStimulus(1'b0);
        bus.iValid = 1; bus.iRs1Addr = 2; bus.iRs2Addr = 7; bus.iRs2Data = 32'h99; bus.iRdAddr = 8;
        #1;
        checkOutput("luStall", {31'd0, bus.oStall}, 32'd1);
        stepCycle();
        #1;
        checkOutput("luBubble", {31'd0, bus.oValid}, 32'd0);
        checkOutput("luStallOnce", {31'd0, bus.oStall}, 32'd0);
        stepCycle();
        bus.iValid = 0; bus.iMemWbRd = 7; bus.iMemWbRegWrite = 1; bus.iMemWbResult = 32'hCAFE;
        #1;
        checkOutput("luValid", {31'd0, bus.oValid}, 32'd1);
        checkOutput("luFwdB", bus.oB, 32'hCAFE);

        // No false stalls: load to x0, and I-type reading only rs1
        applyStimulus(1'b0);
        bus.iValid = 1; bus.iMemRead = 1; bus.iRdAddr = 0;
        stepCycle();
        bus.iMemRead = 0; bus.iRs1Addr = 0;
        #1;
        checkOutput("noStallX0", {31'd0, bus.oStall}, 32'd0);
        bus.iMemRead = 1; bus.iRdAddr = 7;
        stepCycle();
        applyStimulus(1'b0);
        bus.iValid = 1; bus.iRs1Addr = 1; bus.iRs2Addr = 7; bus.iUseImm = 1;
        #1;
        checkOutput("noStallImm", {31'd0, bus.oStall}, 32'd0);
        bus.iMemWrite = 1;
        #1;
        checkOutput("storeStall", {31'd0, bus.oStall}, 32'd1);

        // Flush overrides a hazard
        bus.iMemWrite = 0; bus.iRs1Addr = 7; bus.iRegWrite = 1; bus.iMemRead = 1; bus.iFlush = 1;
        #1;
        checkOutput("flushNoStall", {31'd0, bus.oStall}, 32'd0);
        stepCycle();
        #1;
        checkOutput("flushValid", {31'd0, bus.oValid}, 32'd0);
        checkOutput("flushFlags", {29'd0, bus.oRegWrite, bus.oMemRead, bus.oMemWrite}, 32'd0);

        // Asynchronous reset mid-cycle while a load-use stall is live
        applyStimulus(1'b0);
        bus.iValid = 1; bus.iMemRead = 1; bus.iRegWrite = 1; bus.iRdAddr = 7;
        bus.iRs1Addr = 3; bus.iRs1Data = 32'h77;
        stepCycle();
        bus.iRs1Addr = 7;
        #2;
        checkOutput("preResetStall", {31'd0, bus.oStall}, 32'd1);
        rstN = 1'b0;
        #1;
        checkAllZero("midReset");
        clearEx();
        @(negedge clk);
        rstN = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b1);
            stepCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
